chameleon_usart_rx: RTL and testbench

Receiver for the synchronous serial link from the Chameleon USB microcontroller. This is the inbound counterpart of the reconfigure/USB transmit path. The microcontroller drives a bit clock (usart_clk) and data (usart_tx) into the FPGA. The block deframes bytes, buffers them in a FIFO and hands them to the host-side core over a valid/ready handshake. It drives a CTS-style flow-control line back to the microcontroller. It runs on sysclk alongside cfide.

---
 rtl/chameleon_usart_pkg.sv | 22 ++
 rtl/chameleon_usart_fifo.sv | 82 ++++++++
 rtl/chameleon_usart_rx.sv | 167 ++++++++++++++++
 tb/tb_chameleon_usart_rx.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chameleon_usart_pkg.sv
// Shared definitions for the Chameleon USART receive path.
// Holds the deframer state encoding, the frame bit constants and a parity helper.
// No ports; imported by chameleon_usart_fifo users and chameleon_usart_rx.
package chameleon_usart_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // Even parity: the data bits plus the parity bit must hold an even number of ones.
  function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
    return ~((^data) ^ par);
  endfunction

endpackage

// File: rtl/chameleon_usart_fifo.sv
// Synchronous show-ahead FIFO; head word and valid are registered, 1 clk push->valid when empty.
// Ports: clk_i/reset_i (sync, active high), push_i/push_data_i, pop_i, data_o/valid_o head, count_o, full_o.
// A push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module chameleon_usart_fifo #(
  parameter int FIFO_AW = 4,
  parameter int WIDTH   = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [FIFO_AW:0] count_o,
  output logic             full_o
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q;
  logic               do_push, do_pop, empty_after_pop;

  // Count never exceeds DEPTH, so its MSB alone marks full.
  assign full_o  = count_q[FIFO_AW];
  assign do_pop  = pop_i & valid_q;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    rd_ptr_d = do_pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
    // When nothing stays behind after the pop, the incoming word becomes the head directly.
    empty_after_pop = (count_q == '0) || ((count_q == CW'(1)) && do_pop);
    data_d = data_q;
    if (empty_after_pop) begin
      if (do_push) begin
        data_d = push_data_i;
      end
    end else begin
      data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= (count_d != '0);
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/chameleon_usart_rx.sv
// Chameleon USART receiver: syncs bit clock/data, deframes start+8 data(+parity)+stop LSB-first into a FIFO.
// Ports: clk/reset, serial_clk/serial_rxd in, serial_cts_n out, rx_data/rx_valid/rx_ready, frame/overrun/timeout pulses.
// Optional macro CHAMELEON_USART_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module chameleon_usart_rx
  import chameleon_usart_pkg::*;
#(
  parameter int FIFO_AW        = 4,
  parameter int RTS_MARGIN     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_clk,
  input  logic       serial_rxd,
  output logic       serial_cts_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       timeout_err
);

  localparam int                CW          = FIFO_AW + 1;
  localparam logic [FIFO_AW:0]  DEPTH_C     = CW'(1 << FIFO_AW);
  localparam logic [FIFO_AW:0]  RTS_C       = CW'(RTS_MARGIN);
  localparam int                TCNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST   = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]        BITCNT_LAST = 3'(DATA_BITS - 1);

  logic        sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic        rxd_s1_q, rxd_s2_q;
  logic        rise, rx_bit;

  state_e      state_q;
  logic [2:0]  bitcnt_q;
  logic [7:0]  shift_q;
  logic [TCNT_W-1:0] tcnt_q;
  logic        frame_err_q, overrun_err_q, timeout_err_q;
  logic        cts_n_q, cts_n_d;
  logic        par_ok;

  logic        push, pop, fifo_full;
  logic [FIFO_AW:0] fifo_count;

  // Synchronisers reset to the idle-high level so a reset never manufactures a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1_q <= 1'b1;
      sclk_s2_q <= 1'b1;
      sclk_s3_q <= 1'b1;
      rxd_s1_q  <= 1'b1;
      rxd_s2_q  <= 1'b1;
    end else begin
      sclk_s1_q <= serial_clk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      rxd_s1_q  <= serial_rxd;
      rxd_s2_q  <= rxd_s1_q;
    end
  end

  assign rise   = sclk_s2_q & ~sclk_s3_q;
  assign rx_bit = rxd_s2_q;

`ifdef CHAMELEON_USART_PARITY_EN
  logic par_ok_q;
  assign par_ok = par_ok_q;
`else
  assign par_ok = 1'b1;
`endif

  // The FIFO itself resolves "full but popping this cycle", so push is simply a good stop bit.
  assign push    = rise & (state_q == STOP) & (rx_bit == STOP_BIT) & par_ok;
  assign pop     = rx_valid & rx_ready;
  assign cts_n_d = (DEPTH_C - fifo_count) <= RTS_C;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      tcnt_q        <= '0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      timeout_err_q <= 1'b0;
      cts_n_q       <= 1'b1;
`ifdef CHAMELEON_USART_PARITY_EN
      par_ok_q      <= 1'b1;
`endif
    end else begin
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      timeout_err_q <= 1'b0;
      cts_n_q       <= cts_n_d;

      if (state_q == IDLE) begin
        tcnt_q <= '0;
        if (rise && (rx_bit == START_BIT)) begin
          state_q  <= DATA;
          bitcnt_q <= '0;
          shift_q  <= '0;
        end
      end else if (rise) begin
        tcnt_q <= '0;
        case (state_q)
          DATA: begin
            shift_q  <= {rx_bit, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == BITCNT_LAST) begin
`ifdef CHAMELEON_USART_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
`ifdef CHAMELEON_USART_PARITY_EN
          PARITY: begin
            par_ok_q <= even_parity_ok(shift_q, rx_bit);
            state_q  <= STOP;
          end
`endif
          STOP: begin
            state_q <= IDLE;
            if ((rx_bit != STOP_BIT) || !par_ok) begin
              frame_err_q <= 1'b1;
            end else if (fifo_full && !pop) begin
              overrun_err_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (tcnt_q == TCNT_LAST) begin
        // The bit clock stalled mid-frame: drop the partial byte and resync on a new start bit.
        timeout_err_q <= 1'b1;
        state_q       <= IDLE;
        tcnt_q        <= '0;
        shift_q       <= '0;
        bitcnt_q      <= '0;
      end else begin
        tcnt_q <= tcnt_q + TCNT_W'(1);
      end
    end
  end

  chameleon_usart_fifo #(
    .FIFO_AW (FIFO_AW),
    .WIDTH   (8)
  ) u_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (pop),
    .data_o      (rx_data),
    .valid_o     (rx_valid),
    .count_o     (fifo_count),
    .full_o      (fifo_full)
  );

  assign serial_cts_n = cts_n_q;
  assign frame_err    = frame_err_q;
  assign overrun_err  = overrun_err_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_chameleon_usart_rx.sv
// Self-checking bench for chameleon_usart_rx: directed serial frames plus a queue-based reference model.
// The model decodes frames from the serial pins and checks every DUT output each cycle.
// Directed literal checks pin single-byte, FIFO fill/drain, framing, timeout, reset and parity cases.
module tb_chameleon_usart_rx;

  localparam int T_TO      = 200;
  localparam int HALF      = 4;
  localparam int DEPTH     = 16;
  localparam int MARGIN    = 4;
`ifdef CHAMELEON_USART_PARITY_EN
  localparam int FRAME_LEN = 10;
`else
  localparam int FRAME_LEN = 9;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_clk = 1'b1;
  logic       serial_rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic       serial_cts_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err, overrun_err, timeout_err;

  always #5 clk = ~clk;

  chameleon_usart_rx #(
    .FIFO_AW        (4),
    .RTS_MARGIN     (MARGIN),
    .TIMEOUT_CYCLES (T_TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_clk   (serial_clk),
    .serial_rxd   (serial_rxd),
    .serial_cts_n (serial_cts_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_err    (frame_err),
    .overrun_err  (overrun_err),
    .timeout_err  (timeout_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mq[$];
  logic       m_valid, m_cts, m_ferr, m_oerr, m_terr;
  logic [7:0] m_data;
  bit         m_started = 0;
  logic       pin_clk[3];
  logic       pin_rxd[2];
  bit         in_frame = 0;
  logic       fbits[$];
  int         idle_cnt = 0;

  always @(posedge clk) begin : model_p
    logic       rise_m, bit_m, push_m, pop_m, ok_m;
    logic [7:0] byte_m;
    int         prev_cnt;
    // Pins are seen by the receiver two clk later; a rise is a 0->1 step in that delayed view.
    rise_m = pin_clk[1] & ~pin_clk[2];
    bit_m  = pin_rxd[1];
    pin_clk[2] = pin_clk[1];
    pin_clk[1] = pin_clk[0];
    pin_clk[0] = serial_clk;
    pin_rxd[1] = pin_rxd[0];
    pin_rxd[0] = serial_rxd;
    m_ferr = 1'b0;
    m_oerr = 1'b0;
    m_terr = 1'b0;
    if (reset) begin
      mq.delete();
      m_valid  = 1'b0;
      m_data   = 8'h00;
      m_cts    = 1'b1;
      in_frame = 0;
      idle_cnt = 0;
      for (int i = 0; i < 3; i++) pin_clk[i] = 1'b1;
      for (int i = 0; i < 2; i++) pin_rxd[i] = 1'b1;
    end else begin
      prev_cnt = mq.size();
      pop_m    = m_valid && rx_ready;
      push_m   = 1'b0;
      byte_m   = 8'h00;
      if (in_frame) begin
        if (rise_m) begin
          idle_cnt = 0;
          fbits.push_back(bit_m);
          if (fbits.size() == FRAME_LEN) begin
            in_frame = 0;
            for (int i = 0; i < 8; i++) byte_m[i] = fbits[i];
            ok_m = (fbits[FRAME_LEN-1] == 1'b1);
`ifdef CHAMELEON_USART_PARITY_EN
            if (((^byte_m) ^ fbits[8]) != 1'b0) ok_m = 1'b0;
`endif
            if (ok_m) push_m = 1'b1;
            else m_ferr = 1'b1;
          end
        end else begin
          idle_cnt++;
          if (idle_cnt == T_TO) begin
            m_terr   = 1'b1;
            in_frame = 0;
          end
        end
      end else if (rise_m && bit_m == 1'b0) begin
        in_frame = 1;
        fbits.delete();
        idle_cnt = 0;
      end
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        if (mq.size() < DEPTH) mq.push_back(byte_m);
        else m_oerr = 1'b1;
      end
      m_valid = (mq.size() > 0);
      if (m_valid) m_data = mq[0];
      m_cts = ((DEPTH - prev_cnt) <= MARGIN);
    end
    m_started = 1;
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("rx_valid", {31'h0, rx_valid}, {31'h0, m_valid});
      if (m_valid) chk("rx_data", {24'h0, rx_data}, {24'h0, m_data});
      chk("cts_n", {31'h0, serial_cts_n}, {31'h0, m_cts});
      chk("frame_err", {31'h0, frame_err}, {31'h0, m_ferr});
      chk("overrun_err", {31'h0, overrun_err}, {31'h0, m_oerr});
      chk("timeout_err", {31'h0, timeout_err}, {31'h0, m_terr});
    end
  end

  // ---------------- monitor for directed checks ----------------
  logic [7:0] got[$];
  int n_valid = 0, n_ferr = 0, n_oerr = 0, n_terr = 0;
  int t_cyc = -1;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got.push_back(rx_data);
    if (rx_valid) n_valid++;
    if (frame_err) n_ferr++;
    if (overrun_err) n_oerr++;
    if (timeout_err) begin
      n_terr++;
      if (t_cyc < 0) t_cyc = cyc;
    end
  end

  function automatic logic [31:0] got_at(input int i);
    if (i < got.size()) return {24'h0, got[i]};
    return 32'hDEAD_BEEF;
  endfunction

  // ---------------- stimulus ----------------
  int last_rise_cyc = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_rxd = b;
    serial_clk = 1'b0;
    tick(HALF);
    serial_clk    = 1'b1;
    last_rise_cyc = cyc;
    tick(HALF);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef CHAMELEON_USART_PARITY_EN
    send_bit((^b) ^ bad_par);
`else
    if (bad_par) $display("note: parity not built in");
`endif
    send_bit(stop);
    tick(3);
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int i = 0; i < budget && got.size() < n; i++) tick(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int v0, f0, o0, t0, r0;
    logic [7:0] part;
    tick(1);
    reset = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(1);
    chk("reset_valid0", {31'h0, rx_valid}, 32'h0);
    chk("cts_after_reset", {31'h0, serial_cts_n}, 32'h0);
    tick(2);

    // Single byte with consumer always ready.
    rx_ready = 1'b1;
    got.delete();
    v0 = n_valid; f0 = n_ferr; o0 = n_oerr; t0 = n_terr;
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(5);
    chk("single_count", got.size(), 1);
    chk("single_data", got_at(0), 32'hA5);
    chk("single_valid_cycles", n_valid - v0, 1);
    chk("single_no_err", (n_ferr - f0) + (n_oerr - o0) + (n_terr - t0), 0);

    // FIFO fill with consumer stalled, then drain.
    rx_ready = 1'b0;
    got.delete();
    o0 = n_oerr;
    for (int i = 0; i <= 16; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      if (i == 10) chk("cts_at_11", {31'h0, serial_cts_n}, 32'h0);
      if (i == 11) chk("cts_at_12", {31'h0, serial_cts_n}, 32'h1);
    end
    chk("fill_overrun", n_oerr - o0, 1);
    chk("fill_valid", {31'h0, rx_valid}, 32'h1);
    chk("fill_head", {24'h0, rx_data}, 32'h00);
    rx_ready = 1'b1;
    wait_got(16, 100);
    tick(3);
    chk("drain_count", got.size(), 16);
    for (int i = 0; i < 16; i++) chk("drain_byte", got_at(i), i);
    chk("cts_drained", {31'h0, serial_cts_n}, 32'h0);

    // Bad stop bit, then a good frame.
    got.delete();
    f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(5);
    chk("ferr_pulse", n_ferr - f0, 1);
    chk("ferr_nopush", got.size(), 0);
    send_frame(8'h55, 1'b1, 1'b0);
    tick(5);
    chk("after_ferr_data", got_at(0), 32'h55);

    // Partial frame then stalled bit clock.
    got.delete();
    t0 = n_terr;
    t_cyc = -1;
    part = 8'h1B;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(part[i]);
    r0 = last_rise_cyc;
    for (int i = 0; i < T_TO + 50 && t_cyc < 0; i++) tick(1);
    chk("timeout_seen", {31'h0, (t_cyc >= 0)}, 32'h1);
    chk("timeout_latency", t_cyc - (r0 + 3), T_TO);
    chk("timeout_pulses", n_terr - t0, 1);
    chk("timeout_nopush", got.size(), 0);
    send_frame(8'h81, 1'b1, 1'b0);
    tick(5);
    chk("after_timeout_data", got_at(0), 32'h81);

    // Reset in the middle of a frame with a byte waiting.
    rx_ready = 1'b0;
    got.delete();
    send_frame(8'h42, 1'b1, 1'b0);
    tick(2);
    chk("pre_reset_valid", {31'h0, rx_valid}, 32'h1);
    part = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(part[i]);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_mid_valid", {31'h0, rx_valid}, 32'h0);
    chk("reset_mid_cts", {31'h0, serial_cts_n}, 32'h1);
    reset = 1'b0;
    tick(2);
    rx_ready = 1'b1;
    send_frame(8'hE7, 1'b1, 1'b0);
    tick(5);
    chk("post_reset_count", got.size(), 1);
    chk("post_reset_data", got_at(0), 32'hE7);

`ifdef CHAMELEON_USART_PARITY_EN
    got.delete();
    f0 = n_ferr;
    send_frame(8'h07, 1'b1, 1'b0);
    tick(5);
    chk("parity_good_data", got_at(0), 32'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    tick(5);
    chk("parity_bad_ferr", n_ferr - f0, 1);
    chk("parity_bad_nopush", got.size(), 1);
`endif

    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
